// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states and the timer slave register map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] ADDR_TIMER = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

endpackage

// File: rtl/apb_wait_watchdog.sv
// Saturating wait-state counter; flags expiry once TIMEOUT waits have elapsed.
module apb_wait_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt;

  // Holds at LIMIT rather than wrapping so a stuck slave cannot re-arm the count.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                       wait_cnt <= '0;
    else if (clr)                       wait_cnt <= '0;
    else if (inc && wait_cnt != LIMIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (wait_cnt == LIMIT);

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: single-beat local commands to APB transfers, with a one-cycle
// response pulse and a wait-state watchdog that aborts hung transfers.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e state_q, state_d;
  logic       accept, done, abort, wd_expired;

  apb_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (state_q == SETUP),
    .inc     (state_q == ACCESS && !PREADY),
    .expired (wd_expired)
  );

  assign cmd_ready = (state_q == IDLE) || (state_q == ACCESS && PREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state_q == ACCESS) && PREADY;
  // A ready slave on the expiry cycle still completes normally.
  assign abort     = (state_q == ACCESS) && !PREADY && wd_expired;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done)       state_d = accept ? SETUP : IDLE;
        else if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Bus strobes follow the next state so they line up with the state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      PSEL    <= (state_d != IDLE);
      PENABLE <= (state_d == ACCESS);
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_write ? cmd_wdata : '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= done || abort;
      rsp_rdata   <= (done && !PWRITE) ? PRDATA : '0;
      rsp_err     <= done ? PSLVERR : abort;
      rsp_timeout <= abort;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of single transfers plus hand-written
// back-to-back, timeout and mid-transfer reset sequences.
module tb_apb_master;
  import apb_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [1:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One transfer from IDLE; checks every phase and the response pulse.
  task automatic do_txn(input vec_t v);
    int  n;
    bit  got;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PREADY = 1'b0; PRDATA = v.prdata; PSLVERR = v.slverr;
    #1 chk("ready_idle", cmd_ready, 1);
    @(negedge PCLK); n = 1; cmd_valid = 1'b0;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    chk("setup_pwdata", PWDATA, v.wr ? v.wdata : 8'h00);
    chk("ready_setup", cmd_ready, 0);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge PCLK); n++;
      chk("acc_psel", PSEL, 1);
      chk("acc_penable", PENABLE, 1);
      chk("acc_paddr", PADDR, v.addr);
      chk("acc_no_rsp", rsp_valid, 0);
      PREADY = (k == v.waits);
      #1 chk("acc_ready", cmd_ready, (k == v.waits) ? 1 : 0);
    end
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge PCLK); n++;
      PREADY = 1'b0; PSLVERR = 1'b0;
      if (rsp_valid) got = 1;
    end
    chk("rsp_seen", got, 1);
    chk("rsp_latency", n, v.exp_lat);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_timeout", rsp_timeout, 0);
    chk("rsp_psel", PSEL, 0);
    @(negedge PCLK);
    chk("rsp_single", rsp_valid, 0);
  endtask

  initial begin
    int  n, acc;
    bit  got;
    vec_t post;

    // wr, addr, wdata, waits, prdata, slverr, exp_rdata, exp_err, exp_lat
    vecs[0] = '{1'b1, ADDR_TIMER, 8'h5A,  0, 8'h00, 1'b0, 8'h00, 1'b0,  3};
    vecs[1] = '{1'b0, ADDR_CTRL,  8'h99,  3, 8'hC3, 1'b0, 8'hC3, 1'b0,  6};
    vecs[2] = '{1'b1, ADDR_CTRL,  8'h01,  0, 8'h00, 1'b1, 8'h00, 1'b1,  3};
    vecs[3] = '{1'b0, ADDR_TIMER, 8'h00,  1, 8'h3C, 1'b1, 8'h3C, 1'b1,  4};
    vecs[4] = '{1'b1, ADDR_TIMER, 8'h77,  2, 8'hAA, 1'b0, 8'h00, 1'b0,  5};
    vecs[5] = '{1'b0, 2'd3,       8'hFF,  0, 8'h81, 1'b0, 8'h81, 1'b0,  3};
    vecs[6] = '{1'b0, ADDR_CTRL,  8'h00, 15, 8'h5D, 1'b0, 8'h5D, 1'b0, 18};
    post    = '{1'b1, ADDR_TIMER, 8'hFF,  0, 8'h00, 1'b0, 8'h00, 1'b0,  3};

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Back-to-back writes, cmd_valid held high, slave always ready.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_TIMER; cmd_wdata = 8'h10; PREADY = 1'b1;
    @(negedge PCLK);
    chk("b2b_setup1", {PSEL, PENABLE}, 2'b10);
    chk("b2b_paddr1", PADDR, ADDR_TIMER);
    chk("b2b_pwdata1", PWDATA, 8'h10);
    cmd_addr = ADDR_CTRL; cmd_wdata = 8'h01;
    #1 chk("b2b_ready_setup", cmd_ready, 0);
    @(negedge PCLK);
    chk("b2b_access1", {PSEL, PENABLE}, 2'b11);
    chk("b2b_paddr1_hold", PADDR, ADDR_TIMER);
    chk("b2b_ready_access", cmd_ready, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk("b2b_setup2", {PSEL, PENABLE}, 2'b10);
    chk("b2b_paddr2", PADDR, ADDR_CTRL);
    chk("b2b_pwdata2", PWDATA, 8'h01);
    chk("b2b_rsp1", {rsp_valid, rsp_err}, 2'b10);
    @(negedge PCLK);
    chk("b2b_access2", {PSEL, PENABLE}, 2'b11);
    chk("b2b_gap", rsp_valid, 0);
    @(negedge PCLK);
    chk("b2b_rsp2", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
    chk("b2b_idle", PSEL, 0);
    PREADY = 1'b0;

    // Timeout: slave never ready.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_CTRL; PRDATA = 8'hEE; PREADY = 1'b0;
    @(negedge PCLK); n = 1; cmd_valid = 1'b0;
    acc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK); n++;
      if (rsp_valid) got = 1;
      else if (PSEL && PENABLE) acc++;
    end
    chk("to_seen", got, 1);
    chk("to_latency", n, 18);
    chk("to_access_cycles", acc, 16);
    chk("to_err", rsp_err, 1);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_bus_idle", {PSEL, PENABLE}, 2'b00);
    do_txn(vecs[0]);

    // Reset during an ACCESS wait state.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_CTRL; PREADY = 1'b0;
    @(negedge PCLK); cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("mid_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("mrst_bus", {PSEL, PENABLE}, 2'b00);
    chk("mrst_paddr", PADDR, 0);
    chk("mrst_rsp", rsp_valid, 0);
    repeat (2) begin
      @(negedge PCLK);
      chk("mrst_no_rsp", rsp_valid, 0);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("mrst_after", {PSEL, rsp_valid}, 2'b00);
    do_txn(post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
